// File: rtl/instr_mem_responder_if.sv
// ----------------------------------------------------------------------------
// instr_mem_responder_if
//
// Purpose: fetch-side request/response bundle between the instruction fetch
// unit (master) and the instruction memory responder (slave).
//
// Signals:
//   req_valid  master->slave  request valid
//   req_ready  slave->master  responder can accept a request this cycle
//   req_addr   master->slave  32-bit word address (program counter value)
//   rsp_valid  slave->master  response available
//   rsp_ready  master->slave  consumer accepts the response
//   rsp_instr  slave->master  instruction word
//   rsp_addr   slave->master  echo of the request address
//   rsp_err    slave->master  out-of-range (or parity) error
// ----------------------------------------------------------------------------
interface instr_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_addr;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
  );
endinterface

// File: rtl/instr_mem_responder.sv
// ----------------------------------------------------------------------------
// instr_mem_responder
//
// Purpose: instruction memory behind a valid/ready fetch interface. Requests
// read the memory at accept time, travel through a fixed LATENCY-stage
// pipeline and land in an in-order response FIFO. A credit counter bounds
// the number of outstanding entries to QDEPTH so neither the pipeline nor the
// FIFO ever needs back-pressure. A loader port writes program memory and
// flush drops all in-flight work on a control-flow redirect.
//
// Ports:
//   clk          clock
//   reset        synchronous, active-low reset
//   bus          instr_mem_responder_if.slave (req_* / rsp_* handshakes)
//   flush        discard all outstanding requests and responses
//   wr_en        loader write strobe
//   wr_addr      loader word address (AW bits)
//   wr_data      loader data
//   wr_par_flip  (only with IMEM_PARITY_EN) invert the stored parity bit
//
// Optional feature macro: IMEM_PARITY_EN -- stores an even-parity bit per
// word; a mismatch on read returns the HLT word with rsp_err=1.
// ----------------------------------------------------------------------------
module instr_mem_responder #(
  parameter int         AW         = 8,
  parameter int         LATENCY    = 2,
  parameter int         QDEPTH     = 4,
  parameter logic [7:0] HLT_OPCODE = 8'hFF
) (
  input  logic                  clk,
  input  logic                  reset,
  instr_mem_responder_if.slave  bus,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [31:0]           wr_data
`ifdef IMEM_PARITY_EN
  ,
  input  logic                  wr_par_flip
`endif
);

  localparam int PW = $clog2(QDEPTH);
`ifdef IMEM_PARITY_EN
  localparam int MW = 33;
`else
  localparam int MW = 32;
`endif
  localparam logic [31:0] HLT_WORD = {HLT_OPCODE, 24'h0};
  localparam logic [PW:0] QD       = (PW+1)'(QDEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } rsp_t;

  // Program memory with a registered read port.
  logic [MW-1:0] mem [2**AW];
  logic [MW-1:0] mem_rd_q;
  logic [MW-1:0] wr_word;

  // Pipeline stages. Stage 0 data lives in mem_rd_q, so pipe_data_*[0] is
  // never selected; stages 1..LATENCY-1 carry the word forward.
  logic [LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [31:0]        pipe_addr_q [LATENCY];
  logic [31:0]        pipe_addr_d [LATENCY];
  logic               pipe_oor_q  [LATENCY];
  logic               pipe_oor_d  [LATENCY];
  logic [MW-1:0]      pipe_data_q [LATENCY];
  logic [MW-1:0]      pipe_data_d [LATENCY];

  // Response FIFO and credit counter.
  rsp_t        fifo [QDEPTH];
  logic [PW:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0] cnt_q, cnt_d;

  logic          req_ready;
  logic          rsp_valid;
  logic          accept;
  logic          pop;
  logic          push;
  logic          oor_in;
  logic          rd_en;
  logic [MW-1:0] last_data;
  logic          par_bad;
  logic          last_err;
  rsp_t          push_ent;
  rsp_t          head;
  logic          fifo_empty;

`ifdef IMEM_PARITY_EN
  // Even parity: the stored word including its parity bit XORs to zero.
  assign wr_word = {(^wr_data) ^ wr_par_flip, wr_data};
`else
  assign wr_word = wr_data;
`endif

  assign oor_in     = |bus.req_addr[31:AW];
  assign fifo_empty = (rd_ptr_q == wr_ptr_q);
  assign req_ready  = reset && !flush && (cnt_q < QD);
  assign rsp_valid  = reset && !fifo_empty;
  assign accept     = bus.req_valid && req_ready;
  assign pop        = rsp_valid && bus.rsp_ready;
  // Out-of-range requests do not touch the memory.
  assign rd_en      = accept && !oor_in;

  assign last_data = (LATENCY == 1) ? mem_rd_q : pipe_data_q[LATENCY-1];
`ifdef IMEM_PARITY_EN
  assign par_bad = ^last_data;
`else
  assign par_bad = 1'b0;
`endif
  // Out-of-range entries never read memory, so their stale data is masked.
  assign last_err = pipe_oor_q[LATENCY-1] || par_bad;

  always_comb begin
    push_ent.instr = last_err ? HLT_WORD : last_data[31:0];
    push_ent.addr  = pipe_addr_q[LATENCY-1];
    push_ent.err   = last_err;
  end

  // Flush and reset suppress the push of the entry leaving the pipeline.
  assign push = pipe_vld_q[LATENCY-1] && reset && !flush;

  always_comb begin
    pipe_vld_d[0]  = accept;
    pipe_addr_d[0] = bus.req_addr;
    pipe_oor_d[0]  = oor_in;
    pipe_data_d[0] = '0;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_addr_d[i] = pipe_addr_q[i-1];
      pipe_oor_d[i]  = pipe_oor_q[i-1];
      pipe_data_d[i] = (i == 1) ? mem_rd_q : pipe_data_q[i-1];
    end

    wr_ptr_d = wr_ptr_q + (PW+1)'(push);
    rd_ptr_d = rd_ptr_q + (PW+1)'(pop);

    cnt_d = cnt_q;
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    // Reset outranks flush; both empty the whole datapath.
    if (!reset || flush) begin
      pipe_vld_d = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      cnt_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    pipe_vld_q  <= pipe_vld_d;
    pipe_addr_q <= pipe_addr_d;
    pipe_oor_q  <= pipe_oor_d;
    pipe_data_q <= pipe_data_d;
    wr_ptr_q    <= wr_ptr_d;
    rd_ptr_q    <= rd_ptr_d;
    cnt_q       <= cnt_d;
  end

  // Read-before-write: a same-cycle write to the read address yields the
  // old word because both use the pre-edge memory contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_word;
    end
    if (rd_en) begin
      mem_rd_q <= mem[bus.req_addr[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo[wr_ptr_q[PW-1:0]] <= push_ent;
    end
  end

  assign head = fifo[rd_ptr_q[PW-1:0]];

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_instr = rsp_valid ? head.instr : 32'h0;
  assign bus.rsp_addr  = rsp_valid ? head.addr  : 32'h0;
  assign bus.rsp_err   = rsp_valid ? head.err   : 1'b0;

endmodule

// File: doc/instr_mem_responder.md
Name: instr_mem_responder

Overview:
- Instruction-memory responder on the fetch interface: accepts word addresses from the fetch side and returns the 32-bit instruction word at that address.
- Requests and responses each use a valid/ready handshake, with a fixed read latency and a bounded number of outstanding entries.
- Responses are always returned in request order.
- A loader write port fills program memory; a flush input discards all in-flight work when control flow is redirected (JMP/JMPE/JMPNE taken).

Parameters:
- AW, 8, memory address width; depth = 2**AW words of 32 bits.
- LATENCY, 2, cycles from request accept to the response becoming eligible for the output FIFO; legal range 1..4.
- QDEPTH, 4, maximum outstanding entries (in pipeline plus response FIFO); power of 2, at least 2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  responder can accept a request this cycle.
- req_addr  in  32  word address; the program counter value, not a byte address.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_instr  out  32  instruction word.
- rsp_addr  out  32  echo of the request address.
- rsp_err  out  1  address out of range (or parity error, see Optional Feature).
- flush  in  1  discard all outstanding requests and responses.
- wr_en  in  1  loader write strobe.
- wr_addr  in  AW  loader word address.
- wr_data  in  32  loader data.

Behaviour:
- Reset: synchronous, active-low, on clk posedge.
  - Clears pipeline valids, FIFO pointers and the credit count.
  - Outputs during reset: req_ready=0, rsp_valid=0, rsp_instr=0, rsp_addr=0, rsp_err=0.
  - Memory contents are not cleared.
  - Reset asserted mid-operation drops every in-flight entry; nothing is emitted after reset releases.
- Request accept: occurs when req_valid && req_ready at a posedge.
  - The memory is read at accept time using req_addr[AW-1:0].
  - A same-cycle wr_en to the same address returns the OLD data (read-before-write).
- Out of range: if req_addr[31:AW] != 0, the request still occupies a slot, but returns rsp_instr = {HLT opcode, 24'h0} and rsp_err=1, with no memory read.
- Pipeline: an accepted request advances one stage per cycle for LATENCY stages, then pushes into the response FIFO (depth QDEPTH).
  - Minimum request-to-rsp_valid latency is LATENCY cycles.
  - With rsp_ready held high, throughput is 1 response per cycle.
- Credit count cnt (width log2(QDEPTH)+1):
  - +1 on accept; -1 on response pop (rsp_valid && rsp_ready).
  - Both in the same cycle: unchanged.
  - req_ready = reset && !flush && (cnt < QDEPTH), so the FIFO can never overflow and the pipeline never stalls.
- Response outputs: rsp_instr, rsp_addr and rsp_err are driven from the FIFO head.
  - They hold stable while rsp_valid && !rsp_ready.
  - They return to 0 when the FIFO is empty.
- Flush: at the flush posedge, all pipeline valids, the FIFO and cnt are cleared.
  - req_ready=0 in the flush cycle, so no request is accepted then.
  - A pop in the flush cycle is discarded.
  - rsp_valid=0 from the next cycle; new requests are accepted from the cycle after flush.
- Priority, highest first: reset, then flush, then normal accept/pop.
- Loader write: mem[wr_addr] <= wr_data on posedge when wr_en=1; independent of the handshakes and of flush.
- Ordering: responses are strictly in request order; no reordering or merging.

Optional Feature:
- Macro: IMEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit, computed from wr_data on write.
  - Additional input port wr_par_flip (1 bit): when high with wr_en, the stored parity bit is inverted (error injection).
  - On read, a parity mismatch forces rsp_instr = {HLT opcode, 24'h0} and rsp_err=1; rsp_addr is still echoed.
- Not defined: no parity storage, no wr_par_flip port, and rsp_err reflects out-of-range only.

Test Plan:
- Load mem[0..3] = 32'h11111111..44444444; issue addresses 0,1,2,3 back-to-back with rsp_ready=1 -> responses appear in order with matching rsp_addr; the first arrives LATENCY cycles after accept, then one per cycle.
- Hold rsp_ready=0 and issue 6 requests -> exactly QDEPTH=4 accepted; req_ready low afterward. Pulse rsp_ready for one cycle -> one pop, one new accept, order preserved.
- Request addr 32'h00000100 with AW=8 -> rsp_err=1, rsp_instr = HLT word, rsp_addr=32'h100.
- Three requests outstanding, assert flush for one cycle -> no further rsp_valid; a request on the next cycle to addr 5 returns mem[5] only.
- Same-cycle wr_en to addr 7 (data 32'hDEADBEEF) and accepted request to addr 7 (old data 32'hCAFEF00D) -> response 32'hCAFEF00D; a subsequent read returns 32'hDEADBEEF.
- IMEM_PARITY_EN: write addr 2 with wr_par_flip=1, then read addr 2 -> rsp_err=1 with HLT word. Reset asserted with entries outstanding -> rsp_valid=0 and cnt=0 after release.
